uart_checker_channel: RTL and testbench
=======================================

// Module: uart_checker_channel
// PURPOSE
// One parametrised full-duplex UART checker channel for the testbench library. It replaces the
// fixed 8-bit, fixed-baud checker channel. It adds a runtime baud divider, parity and bit-order
// modes, TX/RX FIFOs, glitch rejection and sticky error reporting. A multi-channel wrapper
// instantiates N copies; the tb_uart class drives it through the checker interface.
// PARAMETERS
// G_DATA_WIDTH         8  data bits per frame, legal 5..9
// G_STOP_BIT_NUMBER    1  stop bits, 1 or 2 (RX checks the first stop bit only)
// G_PARITY             0  0 = none, 1 = even, 2 = odd
// G_FIRST_BIT          0  0 = LSB first, 1 = MSB first
// G_IDLE_LEVEL         1  line idle/stop level; the start bit is ~G_IDLE_LEVEL
// G_BUFFER_ADDR_WIDTH  4  FIFO depth = 2**G_BUFFER_ADDR_WIDTH, same for TX and RX
// PORTS
// clk              in   1        testbench clock
// rst              in   1        synchronous reset, active-high
// i_baud_div       in   16       clk cycles per bit; values < 2 are treated as 2
// i_tx_data        in   DW       byte to send
// i_tx_valid       in   1        TX write request
// o_tx_ready       out  1        TX FIFO not full
// o_tx             out  1        serial output
// o_tx_busy        out  1        FSM not IDLE, or TX FIFO not empty
// o_tx_level       out  AW+1     TX FIFO occupancy
// i_rx             in   1        serial input (asynchronous)
// o_rx_data        out  DW       RX FIFO head (first-word fall-through)
// o_rx_valid       out  1        RX FIFO not empty
// i_rx_ready       in   1        pop the RX FIFO head
// o_rx_level       out  AW+1     RX FIFO occupancy
// o_rx_parity_err  out  1        sticky parity error
// o_rx_frame_err   out  1        sticky framing error
// o_rx_overflow    out  1        sticky RX overflow
// i_clear_err      in   1        clears all three sticky flags
// BEHAVIOUR
// - Reset (any cycle, including mid-frame): next edge sets o_tx=G_IDLE_LEVEL.
//   - Both FIFOs are flushed; levels=0, o_tx_ready=1, o_rx_valid=0, all flags=0.
//   - Both FSMs go to IDLE; the aborted frame is lost.
// - Handshakes: write when i_tx_valid&&o_tx_ready; pop when o_rx_valid&&i_rx_ready.
//   - TX FIFO full: the write is rejected even if a pop happens the same cycle.
// - TX FSM: IDLE->START->DATA(DW bits)->PARITY (skipped if G_PARITY=0)->STOP(x G_STOP_BIT_NUMBER)->IDLE.
//   - IDLE pops the FIFO when it is non-empty and latches max(i_baud_div,2); the latch holds for the whole frame.
//   - Each bit lasts exactly the latched divider cycles.
//   - Latency: idle channel, empty FIFO, accept at cycle N -> start bit on o_tx from edge N+2.
//   - Non-empty FIFO at the end of the last stop bit: next start bit follows with no idle gap.
//   - Parity bit = XOR of the data bits (even) or its inverse (odd).
// - RX path: i_rx passes through a 2-flop synchroniser, which adds 2 cycles of latency.
//   - The RX FSM mirrors TX: IDLE->START->DATA->PARITY->STOP.
//   - IDLE->START on a synchronised level of ~G_IDLE_LEVEL. Divider latched as for TX.
//   - START: at div/2 cycles (integer floor) the line is re-sampled. Still active -> DATA; else glitch -> IDLE, no flag.
//   - Then one sample every div cycles at bit centre; bits are assembled per G_FIRST_BIT.
//   - Parity mismatch: the byte IS pushed and o_rx_parity_err is set.
//   - First stop sample != G_IDLE_LEVEL: the byte is NOT pushed and o_rx_frame_err is set.
//   - FSM returns to IDLE right after the stop-bit sample, so back-to-back frames are received.
//   - Push into a full FIFO is dropped and o_rx_overflow is set; FIFO contents are unchanged.
//   - Push and pop in the same cycle on a full FIFO: the push is accepted and the level stays full.
// - Sticky flags: set 1 cycle after the event; i_clear_err clears them. A set and clear in the same cycle: the set wins.
// - FIFO pointers are AW bits and wrap modulo depth; levels count 0..2**AW.
// - The divider may change at any time; it takes effect at the next frame only.
// TESTING
// - Loopback i_rx=o_tx, div=4, 8N1: send 0xA5 then 0x3C -> RX reads 0xA5, 0x3C; no flags; start bit at accept+2.
// - G_PARITY=1, bench drives 0x0F with parity bit 1 -> 0x0F pushed, parity_err=1; i_clear_err -> 0.
// - Bench drives 0x55 with stop bit 0 -> rx_level stays 0, frame_err=1.
// - AW=2, 5 frames received, i_rx_ready=0 -> level=4, overflow=1, head reads the first 4 bytes in order.
// - div=8, single-cycle low pulse on idle i_rx -> no push, no flags, FSM back in IDLE.
// - rst pulsed mid-TX frame with 3 bytes queued -> o_tx=1 next cycle, tx_level=0, o_tx_busy=0.

Source files
------------

// File: rtl/uart_checker_channel.sv
// Full-duplex UART checker channel: TX/RX FIFOs, runtime baud divider,
// parity and bit-order modes, glitch-rejecting receiver and sticky RX error flags.
module uart_checker_channel #(
    parameter int unsigned G_DATA_WIDTH        = 8,
    parameter int unsigned G_STOP_BIT_NUMBER   = 1,
    parameter int unsigned G_PARITY            = 0,
    parameter int unsigned G_FIRST_BIT         = 0,
    parameter logic        G_IDLE_LEVEL        = 1'b1,
    parameter int unsigned G_BUFFER_ADDR_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [15:0]                    i_baud_div,
    input  logic [G_DATA_WIDTH-1:0]        i_tx_data,
    input  logic                           i_tx_valid,
    output logic                           o_tx_ready,
    output logic                           o_tx,
    output logic                           o_tx_busy,
    output logic [G_BUFFER_ADDR_WIDTH:0]   o_tx_level,
    input  logic                           i_rx,
    output logic [G_DATA_WIDTH-1:0]        o_rx_data,
    output logic                           o_rx_valid,
    input  logic                           i_rx_ready,
    output logic [G_BUFFER_ADDR_WIDTH:0]   o_rx_level,
    output logic                           o_rx_parity_err,
    output logic                           o_rx_frame_err,
    output logic                           o_rx_overflow,
    input  logic                           i_clear_err
);
    localparam int unsigned DW    = G_DATA_WIDTH;
    localparam int unsigned AW    = G_BUFFER_ADDR_WIDTH;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned BW    = 4;
    localparam int unsigned SW    = 2;
    localparam logic IDLE_LVL  = G_IDLE_LEVEL;
    localparam logic START_LVL = ~G_IDLE_LEVEL;
    localparam logic ODD       = (G_PARITY == 2);
    localparam logic HAS_PAR   = (G_PARITY != 0);
    localparam logic MSB_FIRST = (G_FIRST_BIT != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [15:0] div_clamp_c;
    assign div_clamp_c = (i_baud_div < 16'd2) ? 16'd2 : i_baud_div;

    // ---------------- TX path ----------------
    logic [DW-1:0] tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [LW-1:0] tx_level;
    state_t        tx_state, tx_state_d;
    logic [15:0]   tx_cnt, tx_cnt_d, tx_div, tx_div_d;
    logic [BW-1:0] tx_bit, tx_bit_d;
    logic [SW-1:0] tx_stop, tx_stop_d;
    logic [DW-1:0] tx_sh, tx_sh_d, tx_head_c;
    logic          tx_par, tx_par_d;
    logic          tx_line_c, tx_load_c, tx_end_c, tx_wr_c, tx_nempty_c;

    assign tx_head_c   = tx_mem[tx_rd_ptr];
    assign tx_nempty_c = (tx_level != '0);
    assign o_tx_ready  = (tx_level != LW'(DEPTH));
    assign tx_wr_c     = i_tx_valid && o_tx_ready;
    assign o_tx_level  = tx_level;
    assign o_tx_busy   = (tx_state != S_IDLE) || tx_nempty_c;

    // TX next-state: the line value is registered into o_tx one cycle later
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + 16'd1;
        tx_div_d   = tx_div;
        tx_bit_d   = tx_bit;
        tx_stop_d  = tx_stop;
        tx_sh_d    = tx_sh;
        tx_par_d   = tx_par;
        tx_line_c  = IDLE_LVL;
        tx_load_c  = 1'b0;
        tx_end_c   = (tx_cnt == tx_div - 16'd1);
        unique case (tx_state)
            S_IDLE: begin
                tx_cnt_d  = '0;
                tx_load_c = tx_nempty_c;
            end
            S_START: begin
                tx_line_c = START_LVL;
                if (tx_end_c) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = '0;
                end
            end
            S_DATA: begin
                tx_line_c = MSB_FIRST ? tx_sh[DW-1] : tx_sh[0];
                if (tx_end_c) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = MSB_FIRST ? {tx_sh[DW-2:0], 1'b0} : {1'b0, tx_sh[DW-1:1]};
                    tx_bit_d = tx_bit + BW'(1);
                    if (tx_bit == BW'(DW - 1))
                        tx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                tx_line_c = tx_par;
                if (tx_end_c) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_end_c) begin
                    tx_cnt_d = '0;
                    if (tx_stop == SW'(G_STOP_BIT_NUMBER - 1)) begin
                        tx_state_d = S_IDLE;
                        tx_load_c  = tx_nempty_c;
                    end else begin
                        tx_stop_d = tx_stop + SW'(1);
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        // Loading from STOP as well as IDLE gives gap-free back-to-back frames
        if (tx_load_c) begin
            tx_state_d = S_START;
            tx_cnt_d   = '0;
            tx_div_d   = div_clamp_c;
            tx_bit_d   = '0;
            tx_stop_d  = '0;
            tx_sh_d    = tx_head_c;
            tx_par_d   = (^tx_head_c) ^ ODD;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_wr_c)
            tx_mem[tx_wr_ptr] <= i_tx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_div    <= 16'd2;
            tx_bit    <= '0;
            tx_stop   <= '0;
            tx_sh     <= '0;
            tx_par    <= 1'b0;
            o_tx      <= IDLE_LVL;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            tx_state  <= tx_state_d;
            tx_cnt    <= tx_cnt_d;
            tx_div    <= tx_div_d;
            tx_bit    <= tx_bit_d;
            tx_stop   <= tx_stop_d;
            tx_sh     <= tx_sh_d;
            tx_par    <= tx_par_d;
            o_tx      <= tx_line_c;
            tx_wr_ptr <= tx_wr_ptr + AW'(tx_wr_c);
            tx_rd_ptr <= tx_rd_ptr + AW'(tx_load_c);
            tx_level  <= tx_level + LW'(tx_wr_c) - LW'(tx_load_c);
        end
    end

    // ---------------- RX path ----------------
    logic [DW-1:0] rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [LW-1:0] rx_level;
    logic          rx_meta, rx_sync;
    state_t        rx_state, rx_state_d;
    logic [15:0]   rx_cnt, rx_cnt_d, rx_div, rx_div_d;
    logic [BW-1:0] rx_bit, rx_bit_d;
    logic [DW-1:0] rx_sh, rx_sh_d;
    logic          rx_end_c, rx_half_c, rx_push_c, rx_pop_c, rx_acc_c, rx_full_c;
    logic          set_perr_c, set_ferr_c, set_ovf_c;

    assign o_rx_data  = rx_mem[rx_rd_ptr];
    assign o_rx_valid = (rx_level != '0);
    assign o_rx_level = rx_level;
    assign rx_full_c  = (rx_level == LW'(DEPTH));
    assign rx_pop_c   = o_rx_valid && i_rx_ready;
    assign rx_acc_c   = rx_push_c && (!rx_full_c || rx_pop_c);
    assign set_ovf_c  = rx_push_c && rx_full_c && !rx_pop_c;

    // RX next-state: start re-checked at half a bit, then sampled at bit centres
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt + 16'd1;
        rx_div_d   = rx_div;
        rx_bit_d   = rx_bit;
        rx_sh_d    = rx_sh;
        rx_push_c  = 1'b0;
        set_perr_c = 1'b0;
        set_ferr_c = 1'b0;
        rx_end_c   = (rx_cnt == rx_div - 16'd1);
        rx_half_c  = (rx_cnt == (rx_div >> 1) - 16'd1);
        unique case (rx_state)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_sync == START_LVL) begin
                    rx_state_d = S_START;
                    rx_div_d   = div_clamp_c;
                end
            end
            S_START: begin
                if (rx_half_c) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = (rx_sync == START_LVL) ? S_DATA : S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_end_c) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = MSB_FIRST ? {rx_sh[DW-2:0], rx_sync} : {rx_sync, rx_sh[DW-1:1]};
                    rx_bit_d = rx_bit + BW'(1);
                    if (rx_bit == BW'(DW - 1))
                        rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (rx_end_c) begin
                    rx_cnt_d   = '0;
                    set_perr_c = (rx_sync != ((^rx_sh) ^ ODD));
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_end_c) begin
                    rx_state_d = S_IDLE;
                    rx_push_c  = (rx_sync == IDLE_LVL);
                    set_ferr_c = (rx_sync != IDLE_LVL);
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_acc_c)
            rx_mem[rx_wr_ptr] <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta         <= IDLE_LVL;
            rx_sync         <= IDLE_LVL;
            rx_state        <= S_IDLE;
            rx_cnt          <= '0;
            rx_div          <= 16'd2;
            rx_bit          <= '0;
            rx_sh           <= '0;
            rx_wr_ptr       <= '0;
            rx_rd_ptr       <= '0;
            rx_level        <= '0;
            o_rx_parity_err <= 1'b0;
            o_rx_frame_err  <= 1'b0;
            o_rx_overflow   <= 1'b0;
        end else begin
            rx_meta         <= i_rx;
            rx_sync         <= rx_meta;
            rx_state        <= rx_state_d;
            rx_cnt          <= rx_cnt_d;
            rx_div          <= rx_div_d;
            rx_bit          <= rx_bit_d;
            rx_sh           <= rx_sh_d;
            rx_wr_ptr       <= rx_wr_ptr + AW'(rx_acc_c);
            rx_rd_ptr       <= rx_rd_ptr + AW'(rx_pop_c);
            rx_level        <= rx_level + LW'(rx_acc_c) - LW'(rx_pop_c);
            o_rx_parity_err <= set_perr_c || (o_rx_parity_err && !i_clear_err);
            o_rx_frame_err  <= set_ferr_c || (o_rx_frame_err && !i_clear_err);
            o_rx_overflow   <= set_ovf_c || (o_rx_overflow && !i_clear_err);
        end
    end
endmodule

// File: tb/tb_uart_checker_channel.sv
// Bench for uart_checker_channel: an 8N1 LSB-first channel (loopback and direct RX drive)
// and an 8E2 MSB-first channel with a 4-entry FIFO.
module tb_uart_checker_channel;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Channel A: defaults (8N1, LSB first, depth 16)
    logic        rst_a, tx_valid_a, tx_ready_a, tx_a, tx_busy_a, rx_a, rx_drv_a, loop_a;
    logic        rx_valid_a, rx_ready_a, perr_a, ferr_a, ovf_a, clear_a;
    logic [15:0] div_a;
    logic [7:0]  tx_data_a, rx_data_a;
    logic [4:0]  tx_level_a, rx_level_a;
    assign rx_a = loop_a ? tx_a : rx_drv_a;

    // Channel B: even parity, MSB first, two stop bits, depth 4
    logic        rst_b, tx_valid_b, tx_ready_b, tx_b, tx_busy_b, rx_drv_b;
    logic        rx_valid_b, rx_ready_b, perr_b, ferr_b, ovf_b, clear_b;
    logic [15:0] div_b;
    logic [7:0]  tx_data_b, rx_data_b;
    logic [2:0]  tx_level_b, rx_level_b;

    uart_checker_channel u_a (
        .clk(clk), .rst(rst_a), .i_baud_div(div_a),
        .i_tx_data(tx_data_a), .i_tx_valid(tx_valid_a), .o_tx_ready(tx_ready_a),
        .o_tx(tx_a), .o_tx_busy(tx_busy_a), .o_tx_level(tx_level_a),
        .i_rx(rx_a), .o_rx_data(rx_data_a), .o_rx_valid(rx_valid_a), .i_rx_ready(rx_ready_a),
        .o_rx_level(rx_level_a), .o_rx_parity_err(perr_a), .o_rx_frame_err(ferr_a),
        .o_rx_overflow(ovf_a), .i_clear_err(clear_a)
    );

    uart_checker_channel #(
        .G_DATA_WIDTH(8), .G_STOP_BIT_NUMBER(2), .G_PARITY(1), .G_FIRST_BIT(1),
        .G_IDLE_LEVEL(1'b1), .G_BUFFER_ADDR_WIDTH(2)
    ) u_b (
        .clk(clk), .rst(rst_b), .i_baud_div(div_b),
        .i_tx_data(tx_data_b), .i_tx_valid(tx_valid_b), .o_tx_ready(tx_ready_b),
        .o_tx(tx_b), .o_tx_busy(tx_busy_b), .o_tx_level(tx_level_b),
        .i_rx(rx_drv_b), .o_rx_data(rx_data_b), .o_rx_valid(rx_valid_b), .i_rx_ready(rx_ready_b),
        .o_rx_level(rx_level_b), .o_rx_parity_err(perr_b), .o_rx_frame_err(ferr_b),
        .o_rx_overflow(ovf_b), .i_clear_err(clear_b)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_line(input bit to_b, input logic v);
        if (to_b) rx_drv_b = v;
        else      rx_drv_a = v;
    endtask

    // Serialise one frame onto a channel's RX line, each bit held for div cycles
    task automatic drive_frame(input bit to_b, input logic [7:0] data, input bit bad_par,
                               input bit bad_stop, input int div);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(to_b ? data[7-i] : data[i]);
        if (to_b) bits.push_back((^data) ^ bad_par);
        bits.push_back(~bad_stop);
        if (to_b) bits.push_back(1'b1);
        foreach (bits[i]) begin
            set_line(to_b, bits[i]);
            repeat (div) @(negedge clk);
        end
        set_line(to_b, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        int         exp_level;
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t       vecs [7];
    logic       exp_bits [20];
    logic [7:0] exp_q [$];
    logic [7:0] byte_v;
    bit         m_perr, m_ferr;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h00, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b0, 1'b0, 1, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'h0F, 1'b1, 1'b0, 1, 8'h0F, 1'b1, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 1, 8'h81, 1'b0, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 1, 8'h3C, 1'b1, 1'b0};
        vecs[6] = '{8'hA7, 1'b0, 1'b0, 1, 8'hA7, 1'b0, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1; loop_a = 1'b0; rx_drv_a = 1'b1; rx_drv_b = 1'b1;
        div_a = 16'd4; div_b = 16'd6;
        tx_data_a = '0; tx_valid_a = 1'b0; rx_ready_a = 1'b0; clear_a = 1'b0;
        tx_data_b = '0; tx_valid_b = 1'b0; rx_ready_b = 1'b0; clear_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_tx_a", 32'(tx_a), 1);
        chk("rst_tx_ready_a", 32'(tx_ready_a), 1);
        chk("rst_tx_busy_a", 32'(tx_busy_a), 0);
        chk("rst_tx_level_a", 32'(tx_level_a), 0);
        chk("rst_rx_valid_a", 32'(rx_valid_a), 0);
        chk("rst_flags_a", 32'({perr_a, ferr_a, ovf_a}), 0);
        chk("rst_tx_b", 32'(tx_b), 1);
        chk("rst_rx_level_b", 32'(rx_level_b), 0);
        chk("rst_flags_b", 32'({perr_b, ferr_b, ovf_b}), 0);

        // Loopback 0xA5, 0x3C at div 4: exact o_tx waveform, then RX readback
        for (int f = 0; f < 2; f++) begin
            byte_v = (f == 0) ? 8'hA5 : 8'h3C;
            exp_bits[f*10] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[f*10+1+i] = byte_v[i];
            exp_bits[f*10+9] = 1'b1;
        end
        loop_a = 1'b1; div_a = 16'd4;
        tx_data_a = 8'hA5; tx_valid_a = 1'b1;
        @(negedge clk);
        chk("lb_tx_m0", 32'(tx_a), 1);
        chk("lb_level_m0", 32'(tx_level_a), 1);
        tx_data_a = 8'h3C;
        @(negedge clk);
        chk("lb_tx_m1", 32'(tx_a), 1);
        chk("lb_level_m1", 32'(tx_level_a), 1);
        chk("lb_busy_m1", 32'(tx_busy_a), 1);
        tx_valid_a = 1'b0;
        for (int m = 2; m < 88; m++) begin
            @(negedge clk);
            if (tx_a !== (((m - 2) / 4 < 20) ? exp_bits[(m - 2) / 4] : 1'b1))
                chk($sformatf("lb_wave_m%0d", m), 32'(tx_a),
                    32'(((m - 2) / 4 < 20) ? exp_bits[(m - 2) / 4] : 1'b1));
            else
                n_chk++;
        end
        repeat (10) @(negedge clk);
        chk("lb_busy_end", 32'(tx_busy_a), 0);
        chk("lb_rx_level", 32'(rx_level_a), 2);
        chk("lb_rx_first", 32'(rx_data_a), 32'h A5);
        rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;
        chk("lb_rx_second", 32'(rx_data_a), 32'h3C);
        rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;
        chk("lb_rx_empty", 32'(rx_valid_a), 0);
        chk("lb_flags", 32'({perr_a, ferr_a, ovf_a}), 0);

        // Random loopback bursts, divider changed only between bursts
        for (int b = 0; b < 3; b++) begin
            int budget;
            div_a = 16'($urandom_range(0, 9));
            for (int i = 0; i < 5; i++) begin
                tx_data_a = 8'($urandom);
                exp_q.push_back(tx_data_a);
                tx_valid_a = 1'b1;
                @(negedge clk);
            end
            tx_valid_a = 1'b0;
            budget = 0;
            while (exp_q.size() != 0 && budget < 4000) begin
                @(negedge clk);
                budget++;
                rx_ready_a = 1'b0;
                if (rx_valid_a) begin
                    chk($sformatf("rand_lb_b%0d", b), 32'(rx_data_a), 32'(exp_q.pop_front()));
                    rx_ready_a = 1'b1;
                end
            end
            @(negedge clk);
            rx_ready_a = 1'b0;
            chk($sformatf("rand_lb_left_b%0d", b), 32'(exp_q.size()), 0);
            exp_q.delete();
            repeat (40) @(negedge clk);
            chk($sformatf("rand_lb_idle_b%0d", b), 32'({tx_busy_a, rx_valid_a}), 0);
            chk($sformatf("rand_lb_flags_b%0d", b), 32'({perr_a, ferr_a, ovf_a}), 0);
        end

        // Reset in the middle of a frame with three bytes still queued
        loop_a = 1'b0; div_a = 16'd4;
        tx_data_a = 8'h00; tx_valid_a = 1'b1;
        repeat (4) @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_pre_tx", 32'(tx_a), 0);
        chk("mid_pre_level", 32'(tx_level_a), 3);
        rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
        chk("mid_rst_tx", 32'(tx_a), 1);
        chk("mid_rst_level", 32'(tx_level_a), 0);
        chk("mid_rst_busy", 32'(tx_busy_a), 0);
        chk("mid_rst_ready", 32'(tx_ready_a), 1);
        repeat (60) @(negedge clk);
        chk("mid_rst_stays_idle", 32'(tx_a), 1);

        // Framing error: 0x55 with stop bit 0
        div_a = 16'd8;
        drive_frame(1'b0, 8'h55, 1'b0, 1'b1, 8);
        repeat (30) @(negedge clk);
        chk("ferr_level", 32'(rx_level_a), 0);
        chk("ferr_flag", 32'(ferr_a), 1);
        chk("ferr_perr", 32'(perr_a), 0);
        clear_a = 1'b1; @(negedge clk); clear_a = 1'b0;
        chk("ferr_cleared", 32'(ferr_a), 0);

        // Single-cycle glitch rejected, followed by a good frame
        rx_drv_a = 1'b0; @(negedge clk); rx_drv_a = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_level", 32'(rx_level_a), 0);
        chk("glitch_flags", 32'({perr_a, ferr_a, ovf_a}), 0);
        drive_frame(1'b0, 8'h96, 1'b0, 1'b0, 8);
        repeat (30) @(negedge clk);
        chk("glitch_after_level", 32'(rx_level_a), 1);
        chk("glitch_after_data", 32'(rx_data_a), 32'h96);
        rx_ready_a = 1'b1; @(negedge clk); rx_ready_a = 1'b0;

        // Table-driven RX frames on channel B (8E2, MSB first)
        div_b = 16'd6;
        for (int v = 0; v < 7; v++) begin
            drive_frame(1'b1, vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop, 6);
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d_level", v), 32'(rx_level_b), 32'(vecs[v].exp_level));
            if (vecs[v].exp_level != 0)
                chk($sformatf("vec%0d_data", v), 32'(rx_data_b), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_perr", v), 32'(perr_b), 32'(vecs[v].exp_perr));
            chk($sformatf("vec%0d_ferr", v), 32'(ferr_b), 32'(vecs[v].exp_ferr));
            rx_ready_b = rx_valid_b; clear_b = 1'b1;
            @(negedge clk);
            rx_ready_b = 1'b0; clear_b = 1'b0;
            chk($sformatf("vec%0d_after_level", v), 32'(rx_level_b), 0);
            chk($sformatf("vec%0d_after_flags", v), 32'({perr_b, ferr_b}), 0);
        end

        // Overflow: five frames into a four-entry FIFO, nothing popped
        for (int i = 0; i < 5; i++)
            drive_frame(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 6);
        repeat (20) @(negedge clk);
        chk("ovf_level", 32'(rx_level_b), 4);
        chk("ovf_flag", 32'(ovf_b), 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_head%0d", i), 32'(rx_data_b), 32'(8'h11 * (i + 1)));
            rx_ready_b = 1'b1; @(negedge clk); rx_ready_b = 1'b0;
        end
        chk("ovf_drained", 32'(rx_level_b), 0);
        clear_b = 1'b1; @(negedge clk); clear_b = 1'b0;
        chk("ovf_cleared", 32'(ovf_b), 0);

        // Random frames on channel B against a reference model
        m_perr = 1'b0; m_ferr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            int dv, eff;
            bit bp, bs;
            byte_v = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = !bp && ($urandom_range(0, 3) == 0);
            dv = $urandom_range(0, 7);
            eff = (dv < 2) ? 2 : dv;
            div_b = 16'(dv);
            drive_frame(1'b1, byte_v, bp, bs, eff);
            repeat (3 * eff + 6) @(negedge clk);
            m_perr |= bp;
            m_ferr |= bs;
            chk($sformatf("rnd%0d_level", i), 32'(rx_level_b), bs ? 0 : 1);
            if (!bs) begin
                chk($sformatf("rnd%0d_data", i), 32'(rx_data_b), 32'(byte_v));
            end
            rx_ready_b = rx_valid_b; @(negedge clk); rx_ready_b = 1'b0;
        end
        chk("rnd_perr", 32'(perr_b), 32'(m_perr));
        chk("rnd_ferr", 32'(ferr_b), 32'(m_ferr));
        chk("rnd_ovf", 32'(ovf_b), 0);
        chk("b_tx_idle", 32'({tx_b, tx_busy_b}), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
